// File: rtl/dac_spi_responder.sv
// dac_spi_responder
//   SPI responder end of the 24-bit DAC command link. Frames arrive on
//   sclk/din while latch is low and commit on the latch rising edge. The
//   address byte selects nop (00), write DAC code (01) or request readback
//   (02). A readback request makes the following frame shift the word
//   {8'h02, dac_value} out on sdo, MSB first. All SPI inputs are
//   oversampled in the clk domain, so clk must run at least 4x sclk.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   sclk         SPI clock; din sampled on its falling edge, sdo moves on its rising edge
//   latch        frame strobe, low while a frame is active, rising edge commits
//   din          serial data in, MSB first
//   clear        level-sensitive clear, forces dac_value to CLEAR_CODE
//   sdo          serial readback data, MSB first
//   dac_value    DAC code register
//   dac_update   one-clk pulse when dac_value changes by write or clear
//   frame_valid  one-clk pulse on a committed, well-formed frame
//   frame_error  one-clk pulse on a malformed frame or unknown address
//   last_addr    address byte of the last well-formed frame
module dac_spi_responder #(
  parameter int          FRAME_BITS  = 24,
  parameter logic [15:0] CLEAR_CODE  = 16'h8000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        latch,
  input  logic        din,
  input  logic        clear,
  output logic        sdo,
  output logic [15:0] dac_value,
  output logic        dac_update,
  output logic        frame_valid,
  output logic        frame_error,
  output logic [7:0]  last_addr
);

  localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_MAX   = 5'd31;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sclk_sync, latch_sync, din_sync, clear_sync;
  logic                    sclk_q, latch_q, clear_q;
  logic                    sclk_s, latch_s, din_s, clear_s;
  logic                    sclk_fall, sclk_rise, latch_fall, latch_rise, clear_rise;
  logic [FRAME_BITS-1:0]   sr;
  logic [4:0]              bit_cnt;
  logic                    read_pending;
  logic [22:0]             rb_sr;
  logic [4:0]              rb_left;
  logic [23:0]             rb_word;
  logic [7:0]              frame_addr;

  // Multi-flop synchronizers; latch idles high so it resets to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync  <= '0;
      latch_sync <= '1;
      din_sync   <= '0;
      clear_sync <= '0;
      sclk_q     <= 1'b0;
      latch_q    <= 1'b1;
      clear_q    <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], latch};
      din_sync   <= {din_sync[SYNC_STAGES-2:0], din};
      clear_sync <= {clear_sync[SYNC_STAGES-2:0], clear};
      sclk_q     <= sclk_s;
      latch_q    <= latch_s;
      clear_q    <= clear_s;
    end
  end

  assign sclk_s     = sclk_sync[SYNC_STAGES-1];
  assign latch_s    = latch_sync[SYNC_STAGES-1];
  assign din_s      = din_sync[SYNC_STAGES-1];
  assign clear_s    = clear_sync[SYNC_STAGES-1];
  assign sclk_fall  = sclk_q & ~sclk_s;
  assign sclk_rise  = ~sclk_q & sclk_s;
  assign latch_fall = latch_q & ~latch_s;
  assign latch_rise = ~latch_q & latch_s;
  assign clear_rise = ~clear_q & clear_s;
  assign rb_word    = {8'h02, dac_value};
  assign frame_addr = sr[FRAME_BITS-1 -: 8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sr           <= '0;
      bit_cnt      <= '0;
      read_pending <= 1'b0;
      rb_sr        <= '0;
      rb_left      <= '0;
      sdo          <= 1'b0;
      dac_value    <= CLEAR_CODE;
      dac_update   <= 1'b0;
      frame_valid  <= 1'b0;
      frame_error  <= 1'b0;
      last_addr    <= '0;
    end else begin
      dac_update  <= 1'b0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;

      case (state)
        IDLE: begin
          // Keep reloading while idle so the readback reflects the latest code.
          if (read_pending) begin
            rb_sr   <= rb_word[22:0];
            rb_left <= 5'd24;
            sdo     <= rb_word[23];
          end else begin
            rb_left <= '0;
            sdo     <= 1'b0;
          end
          if (latch_fall) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            sr      <= '0;
          end
        end

        SHIFT: begin
          // A falling sclk seen together with the latch rise is not part of the frame.
          if (sclk_fall && !latch_rise) begin
            sr <= {sr[FRAME_BITS-2:0], din_s};
            if (bit_cnt != CNT_MAX)
              bit_cnt <= bit_cnt + 5'd1;
          end
          // rb_left counts the bit currently on sdo plus those still queued.
          if (sclk_rise) begin
            if (rb_left > 5'd1) begin
              sdo     <= rb_sr[22];
              rb_sr   <= {rb_sr[21:0], 1'b0};
              rb_left <= rb_left - 5'd1;
            end else begin
              rb_left <= '0;
              sdo     <= 1'b0;
            end
          end
          if (latch_rise)
            state <= COMMIT;
        end

        COMMIT: begin
          state        <= IDLE;
          read_pending <= 1'b0;
          rb_left      <= '0;
          sdo          <= 1'b0;
          if (bit_cnt != FRAME_CNT) begin
            frame_error <= 1'b1;
          end else begin
            frame_valid <= 1'b1;
            last_addr   <= frame_addr;
            case (frame_addr)
              8'h00: ;
              8'h01: begin
                // A write colliding with an asserted clear is dropped.
                if (!clear_s) begin
                  dac_value  <= sr[15:0];
                  dac_update <= 1'b1;
                end
              end
              8'h02: read_pending <= 1'b1;
              default: frame_error <= 1'b1;
            endcase
          end
        end

        default: state <= IDLE;
      endcase

      // Clear overrides everything else on dac_value, every cycle it is high.
      if (clear_s)
        dac_value <= CLEAR_CODE;
      if (clear_rise)
        dac_update <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dac_spi_responder.sv
// tb_dac_spi_responder
//   Scoreboard bench for dac_spi_responder. Each frame pushes its expected
//   commit outcome to a queue; a monitor pops and compares whenever the DUT
//   pulses frame_valid or frame_error. Readback bits on sdo and commit
//   latency are checked inline as the frame is driven.
module tb_dac_spi_responder;

  localparam int HALF = 4;

  logic        clk = 1'b0;
  logic        rst, sclk, latch, din, clear;
  logic        sdo;
  logic [15:0] dac_value;
  logic        dac_update, frame_valid, frame_error;
  logic [7:0]  last_addr;

  typedef struct packed {
    logic        valid;
    logic        error;
    logic        update;
    logic [15:0] value;
    logic [7:0]  addr;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          update_count = 0;

  logic [15:0] model_dac = 16'h8000;
  logic [7:0]  model_addr = 8'h00;
  logic        model_pending = 1'b0;

  dac_spi_responder dut (
    .clk(clk), .rst(rst), .sclk(sclk), .latch(latch), .din(din),
    .clear(clear), .sdo(sdo), .dac_value(dac_value), .dac_update(dac_update),
    .frame_valid(frame_valid), .frame_error(frame_error), .last_addr(last_addr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pop one expectation per commit pulse and compare the committed state.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (frame_valid || frame_error)) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_commit", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("frame_valid", 32'(frame_valid), 32'(e.valid));
        checkOutput("frame_error", 32'(frame_error), 32'(e.error));
        checkOutput("dac_update",  32'(dac_update),  32'(e.update));
        checkOutput("dac_value",   32'(dac_value),   32'(e.value));
        checkOutput("last_addr",   32'(last_addr),   32'(e.addr));
      end
    end
    if (!rst && dac_update)
      update_count++;
  end

  // Drive one frame of nbits (MSB first from bits[nbits-1]) and model its result.
  task automatic applyStimulus(input logic [31:0] bits, input int nbits);
    exp_t        e;
    logic [23:0] rb;
    logic        rb_on;
    logic [7:0]  a;
    int          lat;
    logic        want_bit;

    rb_on = model_pending;
    rb    = {8'h02, model_dac};
    e.valid = 1'b0; e.error = 1'b0; e.update = 1'b0;
    if (nbits != 24) begin
      e.error = 1'b1;
    end else begin
      a = bits[23:16];
      e.valid = 1'b1;
      model_addr = a;
      if (a == 8'h01 && !clear) begin
        model_dac = bits[15:0];
        e.update = 1'b1;
      end else if (a != 8'h00 && a != 8'h01 && a != 8'h02) begin
        e.error = 1'b1;
      end
    end
    model_pending = (nbits == 24) && (bits[23:16] == 8'h02);
    e.value = model_dac;
    e.addr  = model_addr;
    exp_q.push_back(e);

    latch = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < nbits; i++) begin
      din = bits[nbits-1-i];
      wait_clks(HALF);
      want_bit = (rb_on && i < 24) ? rb[23-i] : 1'b0;
      checkOutput($sformatf("sdo_bit%0d", i), 32'(sdo), 32'(want_bit));
      sclk = 1'b1;
      wait_clks(HALF);
      sclk = 1'b0;
      wait_clks(HALF);
    end
    checkOutput("sdo_after_frame", 32'(sdo), 32'd0);

    latch = 1'b1;
    lat = 99;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (frame_valid || frame_error) begin
        lat = k;
        break;
      end
    end
    checkOutput("commit_latency", 32'(lat), 32'd4);
    wait_clks(HALF);
  endtask

  int upd_before;

  initial begin
    rst = 1'b1; sclk = 1'b0; latch = 1'b1; din = 1'b0; clear = 1'b0;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(5);
    checkOutput("reset_dac_value",   32'(dac_value),   32'h8000);
    checkOutput("reset_sdo",         32'(sdo),         32'd0);
    checkOutput("reset_last_addr",   32'(last_addr),   32'd0);
    checkOutput("reset_pulses",      32'({dac_update, frame_valid, frame_error}), 32'd0);

    // Basic write
    applyStimulus(32'h01_1234, 24);
    // Write, readback request, nop that carries the readback, then a plain frame
    applyStimulus(32'h01_ABCD, 24);
    applyStimulus(32'h02_0001, 24);
    applyStimulus(32'h00_0000, 24);
    applyStimulus(32'h00_0000, 24);
    // Malformed frames: short, long, empty
    applyStimulus(32'h0_1234_5, 20);
    applyStimulus(32'h0_01_5A5A | 32'h0100_0000, 25);
    applyStimulus(32'h0, 0);
    // Unknown address
    applyStimulus(32'h07_5555, 24);

    // Clear held across a write commit
    upd_before = update_count;
    clear = 1'b1;
    model_dac = 16'h8000;
    wait_clks(8);
    checkOutput("clear_rise_update", 32'(update_count - upd_before), 32'd1);
    checkOutput("clear_dac_value",   32'(dac_value), 32'h8000);
    applyStimulus(32'h01_0F0F, 24);
    checkOutput("clear_no_extra_update", 32'(update_count - upd_before), 32'd1);
    checkOutput("clear_hold_value",  32'(dac_value), 32'h8000);
    clear = 1'b0;
    wait_clks(8);
    applyStimulus(32'h01_0F0F, 24);
    checkOutput("post_clear_value",  32'(dac_value), 32'h0F0F);

    wait_clks(10);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dac_spi_responder.md
Name: dac_spi_responder

Overview:
- SPI slave (responder) end of the 24-bit DAC command link.
- Receives frames on sclk/din, framed by an active-low latch, decodes the address byte and holds the DAC code register; serves readback data on sdo.
- Used as a synthesizable DAC stand-in for loopback tests on the Opal Kelly fabric, and as the verification target for the SPI master.
- All SPI inputs are oversampled in the single system clock domain.

Parameters:
- FRAME_BITS, 24, bits per valid frame (8 address + 16 data).
- CLEAR_CODE, 16'h8000, value loaded into the DAC register on reset or clear (midscale).
- SYNC_STAGES, 2, synchronizer flops on sclk, latch, din and clear (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 4x the sclk frequency.
- rst  input  1  synchronous, active-high reset.
- sclk  input  1  SPI serial clock from the master.
- latch  input  1  frame strobe; low = frame active, rising edge = commit.
- din  input  1  serial data, MSB first, sampled on the sclk falling edge.
- clear  input  1  DAC clear request; level-sensitive, active high.
- sdo  output  1  serial readback data, MSB first, updated on the sclk rising edge.
- dac_value  output  16  current DAC code register.
- dac_update  output  1  one-clk pulse when dac_value changes through a write or clear.
- frame_valid  output  1  one-clk pulse on a committed, well-formed frame.
- frame_error  output  1  one-clk pulse on a malformed frame.
- last_addr  output  8  address byte of the last well-formed frame.

Behaviour:
- Reset (rst high at a clk edge):
  - dac_value = CLEAR_CODE; sdo = 0; all pulses = 0; last_addr = 0.
  - Bit counter = 0; read_pending = 0; state = IDLE.
  - Synchronizer flops: sclk/din/clear = 0, latch = 1.
  - Reset mid-frame aborts the frame with no error pulse.
- Input sampling: sclk, latch, din and clear each pass through SYNC_STAGES flops. Edges are detected from the last two synchronized samples.
- State IDLE:
  - Synchronized latch falling -> SHIFT; counter = 0; shift register = 0.
  - If read_pending = 1, load the readback word {8'h02, dac_value} into the output shifter and drive its MSB on sdo.
- State SHIFT:
  - Each sclk falling edge: shift register = {sr[22:0], din_sync}; counter increments, saturating at 31.
  - Each sclk rising edge while the readback shifter is loaded: shift it left and present the next bit on sdo. sdo = 0 once all 24 bits are out, and whenever no readback is loaded.
  - Synchronized latch rising -> COMMIT.
  - If a sclk falling edge and a latch rising edge are detected in the same clk cycle, the bit is NOT captured.
- State COMMIT (exactly one clk, then IDLE):
  - counter != FRAME_BITS: frame_error = 1; no register change; read_pending cleared.
  - counter == FRAME_BITS: frame_valid = 1; last_addr = sr[23:16]; read_pending cleared, then:
    - 8'h00: nop.
    - 8'h01: dac_value = sr[15:0]; dac_update = 1.
    - 8'h02: read_pending = 1; the next frame returns the readback word.
    - Any other address: frame_error = 1 in addition to frame_valid; no register change.
  - sdo = 0.
- Clear:
  - Synchronized clear high, in any state, forces dac_value = CLEAR_CODE every cycle.
  - dac_update pulses only on the cycle clear first goes high.
  - A write commit in the same cycle as clear high is discarded; clear wins. frame_valid still pulses.
- Latency: external latch rise -> dac_value update = SYNC_STAGES + 2 clk cycles (synchronizer, edge detect, COMMIT register). dac_update is coincident with the new dac_value.
- A latch low pulse with no sclk edges produces frame_error (counter = 0).

Test Plan:
- Reset release, no traffic -> dac_value = 16'h8000, sdo = 0, no pulses, last_addr = 0.
- Write frame 24'h01_1234 -> single dac_update, dac_value = 16'h1234 exactly 4 clk after latch rise; frame_valid = 1; last_addr = 8'h01.
- Write 24'h01_ABCD, then read 24'h02_0001, then nop 24'h00_0000 -> during the nop frame sdo shifts out 24'h02_ABCD MSB first; after the nop, read_pending = 0 and a further frame gives sdo = 0.
- Short frame of 20 bits with address 8'h01 -> frame_error pulse; dac_value unchanged. 25-bit frame -> frame_error pulse.
- Unknown address 24'h07_5555 -> frame_valid and frame_error both pulse; dac_value unchanged; last_addr = 8'h07.
- clear held high across the commit of write 24'h01_0F0F -> dac_value stays 16'h8000, one dac_update pulse at clear rise. After clear drops, write 24'h01_0F0F -> dac_value = 16'h0F0F.
